// File: rtl/nco_ctrl_pkg.sv
// Shared types for the NCO sweep controller: sequencer states and waveform select codes.
// DWELL_DN exists only when NCO_SWEEP_BIDIR_EN is defined (triangle sweeps).
package nco_ctrl_pkg;

  localparam int NCO_ACC_W = 28;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DWELL = 3'd2,
    DONE  = 3'd3
`ifdef NCO_SWEEP_BIDIR_EN
    , DWELL_DN = 3'd4
`endif
  } state_t;

  typedef enum logic [1:0] {
    WAVE_SIN   = 2'd0,
    WAVE_RECT  = 2'd1,
    WAVE_SAW   = 2'd2,
    WAVE_NOISE = 2'd3
  } wave_t;

endpackage

// File: rtl/nco_dwell_timer.sv
// Dwell counter: load clears, enable counts up, tc flags count == last (combinational, zero latency).
// No backpressure; the sequencer reloads it on tc to start the next step.
module nco_dwell_timer #(
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] last,
  output logic               tc
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == last);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer feeding one multi_nco (freq/pha/wavesel/accum_rst); all outputs registered.
// Optional NCO_SWEEP_BIDIR_EN adds cfg_bidir for up-then-down triangle sweeps. Start accepted only in IDLE; abort wins.
module nco_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int ACC_W   = NCO_ACC_W,
  parameter int DWELL_W = 24,
  parameter int REP_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ACC_W-1:0]   cfg_start_freq,
  input  logic [ACC_W-1:0]   cfg_stop_freq,
  input  logic [ACC_W-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [REP_W-1:0]   cfg_repeat,
  input  logic [ACC_W-1:0]   cfg_pha,
  input  logic [1:0]         cfg_wavesel,
`ifdef NCO_SWEEP_BIDIR_EN
  input  logic               cfg_bidir,
`endif
  input  logic               start,
  input  logic               abort,
  output logic [ACC_W-1:0]   freq,
  output logic [ACC_W-1:0]   pha,
  output logic [1:0]         wavesel,
  output logic               accum_rst,
  output logic               busy,
  output logic               done,
  output logic               sweep_trig
);

  state_t             state;
  logic [ACC_W-1:0]   sh_start, sh_stop, sh_step, sh_pha;
  logic [DWELL_W-1:0] sh_dwell_last;
  logic [REP_W-1:0]   sh_repeat, rep_cnt, rep_next;
  wave_t              sh_wave;

  logic [ACC_W:0]     up_sum;
  logic               up_ok, go_up, in_dwell, rep_last, tc;
`ifdef NCO_SWEEP_BIDIR_EN
  logic               sh_bidir;
  logic [ACC_W:0]     dn_diff;
  logic               dn_ok, go_dn;
`endif

  // Step arithmetic is one bit wider so a carry/borrow ends the sweep instead of wrapping.
  always_comb begin
    up_sum   = {1'b0, freq} + {1'b0, sh_step};
    up_ok    = (sh_step != '0) && !up_sum[ACC_W] && (up_sum[ACC_W-1:0] <= sh_stop);
    go_up    = (state == DWELL) && up_ok;
    rep_next = rep_cnt + 1'b1;
    rep_last = (sh_repeat != '0) && (rep_next == sh_repeat);
    in_dwell = (state == DWELL);
`ifdef NCO_SWEEP_BIDIR_EN
    in_dwell = (state == DWELL) || (state == DWELL_DN);
    dn_diff  = {1'b0, freq} - {1'b0, sh_step};
    dn_ok    = (sh_step != '0) && !dn_diff[ACC_W] && (dn_diff[ACC_W-1:0] >= sh_start);
    go_dn    = dn_ok && (((state == DWELL) && !up_ok && sh_bidir) || (state == DWELL_DN));
`endif
  end

  nco_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load ((state == SYNC) || (in_dwell && tc)),
    .en   (in_dwell),
    .last (sh_dwell_last),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      freq          <= '0;
      pha           <= '0;
      wavesel       <= '0;
      accum_rst     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      sweep_trig    <= 1'b0;
      sh_start      <= '0;
      sh_stop       <= '0;
      sh_step       <= '0;
      sh_pha        <= '0;
      sh_dwell_last <= '0;
      sh_repeat     <= '0;
      sh_wave       <= WAVE_SIN;
      rep_cnt       <= '0;
`ifdef NCO_SWEEP_BIDIR_EN
      sh_bidir      <= 1'b0;
`endif
    end else begin
      accum_rst  <= 1'b0;
      sweep_trig <= 1'b0;
      done       <= 1'b0;
      if (abort && (state != IDLE)) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              sh_start      <= cfg_start_freq;
              sh_stop       <= cfg_stop_freq;
              sh_step       <= cfg_step;
              sh_pha        <= cfg_pha;
              sh_dwell_last <= (cfg_dwell == '0) ? '0 : cfg_dwell - 1'b1;
              sh_repeat     <= cfg_repeat;
              sh_wave       <= wave_t'(cfg_wavesel);
`ifdef NCO_SWEEP_BIDIR_EN
              sh_bidir      <= cfg_bidir;
`endif
              rep_cnt       <= '0;
              state         <= SYNC;
              accum_rst     <= 1'b1;
              sweep_trig    <= 1'b1;
              busy          <= 1'b1;
            end
          end
          SYNC: begin
            freq    <= sh_start;
            pha     <= sh_pha;
            wavesel <= sh_wave;
            state   <= DWELL;
          end
`ifdef NCO_SWEEP_BIDIR_EN
          DWELL, DWELL_DN: begin
`else
          DWELL: begin
`endif
            if (tc) begin
              if (go_up) begin
                freq <= up_sum[ACC_W-1:0];
`ifdef NCO_SWEEP_BIDIR_EN
              end else if (go_dn) begin
                freq  <= dn_diff[ACC_W-1:0];
                state <= DWELL_DN;
`endif
              end else begin
                // Sweep boundary: either finish or restart phase-coherently through SYNC.
                rep_cnt <= rep_next;
                if (rep_last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  state      <= SYNC;
                  accum_rst  <= 1'b1;
                  sweep_trig <= 1'b1;
                end
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Sequencer driving the control inputs of one multi_nco instance: freq, pha, wavesel, accum_rst. Runs a programmable stepped frequency sweep (start, stop, step, dwell per step), repeated N times or forever. Sits between register/config logic and a multi_nco. One instance per NCO channel in the AWG top.
- Start/abort handshake.
- Per-sweep trigger pulse for the pmod header.

Parameters:
ACC_W, 28, NCO phase-accumulator/tuning-word width (full scale 268435456 = 2^28)
DWELL_W, 24, dwell counter width (clock cycles per frequency step)
REP_W, 16, sweep repeat counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cfg_start_freq  in  ACC_W  first tuning word
cfg_stop_freq  in  ACC_W  last tuning word (inclusive bound)
cfg_step  in  ACC_W  tuning-word increment per step
cfg_dwell  in  DWELL_W  cycles per step; 0 treated as 1
cfg_repeat  in  REP_W  sweeps to run; 0 = infinite
cfg_pha  in  ACC_W  phase offset passed to NCO
cfg_wavesel  in  2  0 sin, 1 rect, 2 saw, 3 noise
start  in  1  1-cycle request; sampled in IDLE only
abort  in  1  level/pulse; stops sequence
freq  out  ACC_W  to multi_nco.freq
pha  out  ACC_W  to multi_nco.pha
wavesel  out  2  to multi_nco.wavesel
accum_rst  out  1  to multi_nco.accum_rst, high for one cycle per sweep start
busy  out  1  high from SYNC through last DWELL
done  out  1  1-cycle pulse on normal completion
sweep_trig  out  1  1-cycle pulse coincident with accum_rst

Behaviour:
- Reset values: freq=0, pha=0, wavesel=0, accum_rst=0, busy=0, done=0, sweep_trig=0, state IDLE, counters 0. All outputs registered.
- IDLE:
  - On start=1 && abort=0, latch all cfg_* into shadow registers.
  - Go to SYNC next cycle; cfg changes after that are ignored until the next start.
  - freq/pha/wavesel hold last values, so the NCO keeps running.
- SYNC (1 cycle):
  - freq<=start, pha<=cfg_pha, wavesel<=cfg_wavesel.
  - accum_rst=1, sweep_trig=1, busy=1.
  - Dwell counter<=0. Next: DWELL.
- DWELL: count clk cycles. At count==max(dwell,1)-1, evaluate end of step:
  - Next word nf=freq+step computed in ACC_W+1 bits.
  - If step==0, or nf carry out, or nf>stop: sweep ends.
  - Otherwise freq<=nf[ACC_W-1:0], counter<=0, stay in DWELL.
- Latency: freq updates the cycle after the last dwell cycle; each step lasts exactly max(dwell,1) cycles.
- Sweep end:
  - rep_cnt++.
  - If repeat!=0 && rep_cnt==repeat: go to DONE.
  - Else go to SYNC, giving a phase-coherent restart.
- DONE (1 cycle): done=1, busy=0, then IDLE; freq holds the final step value.
- stop<start: single step at start_freq per sweep.
- start==stop: one step per sweep.
- abort=1 in any non-IDLE state: IDLE next cycle; done not pulsed; outputs hold. Abort beats start in the same cycle.
- start while busy: ignored.
- Async reset mid-sweep: immediate return to reset values.

Optional Feature:
NCO_SWEEP_BIDIR_EN
- With it: extra input cfg_bidir (1 bit, latched at start). When 1, each sweep ends by stepping down again, giving a triangle:
  - After reaching the top step, freq decrements by step. The down boundary check uses borrow or nf<start.
  - The sweep ends after the start_freq step.
  - The top step is not repeated.
  - SYNC fires only between full up-down sweeps.
- Without it: port absent, sawtooth sweep only.

Decomposition:
- Package nco_ctrl_pkg:
  - localparam NCO_ACC_W=28.
  - typedef enum logic[2:0] state_t {IDLE,SYNC,DWELL,DONE}, plus DWELL_DN under the macro.
  - typedef enum logic[1:0] wave_t {WAVE_SIN,WAVE_RECT,WAVE_SAW,WAVE_NOISE}.
- Sub-module nco_dwell_timer: load/enable/terminal-count counter of DWELL_W bits.

Test Plan:
- start=100, stop=400, step=100, dwell=3, repeat=1 -> freq steps 100,200,300,400, each held 3 cycles; accum_rst/sweep_trig single pulse at SYNC; done pulse 12 cycles after the first DWELL cycle; busy low after.
- Same config, repeat=2 -> second SYNC pulse immediately after the 400 step; done after 24 DWELL cycles total.
- start=0x0FFFFF00, step=0x200, stop=0x0FFFFFFF, dwell=1 -> carry detected; no wrap to 0x100; sweep ends after one step.
- repeat=0, abort after 50 cycles -> IDLE next cycle, no done, freq held, busy=0; start in the same cycle as abort is ignored.
- Drive rst low mid-DWELL with freq=300 -> all outputs 0 asynchronously; after release, IDLE until start.
- NCO_SWEEP_BIDIR_EN, bidir=1, 100..300 step 100, dwell=2 -> freq sequence 100,200,300,200,100 then done.
